uart_time_reporter: RTL and testbench
=====================================

UART_TIME_REPORTER -- requirements
Module: uart_time_reporter

Interface
REQ-001 Parameter Separator, default 8'h3A, ASCII byte sent between hours and minutes.
REQ-002 Parameter UseCrLf, default 1: 1 ends the frame with CR LF, 0 ends it with LF only.
REQ-003 clock  in  1  system clock, rising-edge active.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 sendRequest  in  1  request one time frame; sampled on every rising edge.
REQ-006 minutes  in  6  current minutes, binary, 0..59.
REQ-007 hours  in  6  current hours, binary, 0..23.
REQ-008 uartReady  in  1  high while the UART transmitter is idle.
REQ-009 uartStart  out  1  one-clock start pulse to the UART transmitter.
REQ-010 uartData  out  8  byte for the UART transmitter; held stable from uartStart until uartReady returns high.
REQ-011 busy  out  1  high while a frame is in progress.

Function
REQ-012 Frame SHALL be: hours tens, hours units, Separator, minutes tens, minutes units, CR (only if UseCrLf=1), LF.
  - 7 bytes when UseCrLf=1, 6 bytes when UseCrLf=0.
REQ-013 Digits SHALL be ASCII 8'h30 plus the decimal digit of the value.
  - Defined for the full 0..63 input range; 63 yields "63".
REQ-014 On the edge that sees sendRequest=1 in IDLE, the block SHALL snapshot hours/minutes, set busy=1 and enter SEND with byte index 0.
  - Input changes during the frame do not alter the frame.
REQ-015 State machine SHALL be: IDLE, SEND, WAIT_ACK, WAIT_DONE.
REQ-016 SEND: when uartReady=1, the block SHALL drive uartData with the indexed byte, pulse uartStart for exactly one cycle and move to WAIT_ACK.
  - uartStart is registered; it is never high for two consecutive cycles.
REQ-017 WAIT_ACK: the block SHALL remain until uartReady=0, then move to WAIT_DONE.
REQ-018 WAIT_DONE: when uartReady=1, the block SHALL advance the index; after the last byte it returns to IDLE with busy=0, otherwise it returns to SEND.
REQ-019 sendRequest while busy SHALL set a single pending flag; further requests while the flag is set are dropped.
REQ-020 When the frame ends with pending set, the block SHALL clear pending and start a new frame on the next cycle, taking a fresh snapshot.
REQ-021 sendRequest held high SHALL produce back-to-back frames, not a lockup.
REQ-022 Latency: sendRequest sampled at edge k with uartReady=1 SHALL produce uartStart=1 in the cycle after edge k+1.

Reset
REQ-023 While reset=1 at an edge: state=IDLE, uartStart=0, uartData=8'h00, busy=0, index=0, pending=0, snapshot=0.
REQ-024 Reset during a frame SHALL abort it immediately; no further uartStart is issued for the aborted frame.
REQ-025 sendRequest on the same edge as reset SHALL be ignored.

Configuration
REQ-026 With macro UART_TIME_REPORTER_AUTO_EN defined, a change of minutes versus its last registered value SHALL act as a sendRequest.
  - The change is subject to the same pending rules as sendRequest.
  - The last-value register resets to 0.
REQ-027 Without UART_TIME_REPORTER_AUTO_EN, only sendRequest starts frames and no last-value register exists.

Structure
REQ-028 Shared package SHALL hold: state encoding, ASCII constants (zero 8'h30, CR 8'h0D, LF 8'h0A) and frame-length constants (7 and 6).
REQ-029 One combinational sub-module bin_to_ascii2 SHALL convert a 6-bit value to two ASCII digits; it is instantiated twice (hours, minutes).

Verification
REQ-030 hours=13, minutes=7, uartReady model (drops 1 cycle after start, rises 20 cycles later), pulse sendRequest -> bytes 31 33 3A 30 37 0D 0A, busy low after the 7th byte.
REQ-031 UseCrLf=0, hours=0, minutes=0 -> bytes 30 30 3A 30 30 0A, exactly 6 uartStart pulses.
REQ-032 Three sendRequest pulses during one frame -> exactly two frames total; the second carries the values present at its start.
REQ-033 reset asserted after the 3rd byte -> uartStart, busy and uartData all 0 next cycle; no further bytes; a new request afterwards sends a full frame.
REQ-034 uartReady held 0 at request -> no uartStart until uartReady=1; then uartStart pulses exactly one cycle.
REQ-035 UART_TIME_REPORTER_AUTO_EN defined, minutes 59->0 with hours 23->0 -> one frame "00:00\r\n"; without the macro -> no frame.

Source files
------------

// File: rtl/uart_time_reporter_pkg.sv
// Shared definitions for the UART time reporter: FSM encoding, ASCII constants
// and frame lengths.
package uart_time_reporter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam int unsigned FRAME_LEN_CRLF = 7;
    localparam int unsigned FRAME_LEN_LF   = 6;

endpackage

// File: rtl/uart_time_reporter_bin_to_ascii2.sv
// Combinational 6-bit binary to two ASCII decimal digits (0..63 -> "00".."63").
module bin_to_ascii2
    import uart_time_reporter_pkg::*;
(
    input  logic [5:0] value,
    output logic [7:0] tens,
    output logic [7:0] units
);

    logic [5:0] quotient;
    logic [5:0] remainder;

    assign quotient  = value / 6'd10;
    assign remainder = value - quotient * 6'd10;
    assign tens      = ASCII_ZERO + {2'b00, quotient};
    assign units     = ASCII_ZERO + {2'b00, remainder};

endmodule

// File: rtl/uart_time_reporter.sv
// Sends "HH:MM\r\n" (or "HH:MM\n") to a UART transmitter on request.
// Define UART_TIME_REPORTER_AUTO_EN to also send a frame whenever minutes change.
module uart_time_reporter
    import uart_time_reporter_pkg::*;
#(
    parameter logic [7:0] Separator = 8'h3A,
    parameter bit         UseCrLf   = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sendRequest,
    input  logic [5:0] minutes,
    input  logic [5:0] hours,
    input  logic       uartReady,
    output logic       uartStart,
    output logic [7:0] uartData,
    output logic       busy
);

    localparam logic [2:0] LAST_INDEX = UseCrLf ? 3'(FRAME_LEN_CRLF - 1) : 3'(FRAME_LEN_LF - 1);

    state_t     state, state_next;
    logic [2:0] index, index_next;
    logic       pending, pending_next;
    logic       snap_load;
    logic       start_next;
    logic [7:0] data_next;
    logic [7:0] frame_byte;
    logic [5:0] hours_snap, minutes_snap;
    logic [7:0] hours_tens, hours_units, minutes_tens, minutes_units;
    logic       request;

`ifdef UART_TIME_REPORTER_AUTO_EN
    logic [5:0] minutes_last;

    always_ff @(posedge clock) begin
        if (reset) minutes_last <= '0;
        else       minutes_last <= minutes;
    end

    assign request = sendRequest || (minutes != minutes_last);
`else
    assign request = sendRequest;
`endif

    bin_to_ascii2 u_hours_ascii (
        .value (hours_snap),
        .tens  (hours_tens),
        .units (hours_units)
    );

    bin_to_ascii2 u_minutes_ascii (
        .value (minutes_snap),
        .tens  (minutes_tens),
        .units (minutes_units)
    );

    always_comb begin
        frame_byte = ASCII_LF;
        case (index)
            3'd0:    frame_byte = hours_tens;
            3'd1:    frame_byte = hours_units;
            3'd2:    frame_byte = Separator;
            3'd3:    frame_byte = minutes_tens;
            3'd4:    frame_byte = minutes_units;
            3'd5:    frame_byte = UseCrLf ? ASCII_CR : ASCII_LF;
            default: frame_byte = ASCII_LF;
        endcase
    end

    // Requests arriving mid-frame collapse into one pending flag, served from IDLE.
    always_comb begin
        state_next   = state;
        index_next   = index;
        pending_next = pending;
        snap_load    = 1'b0;
        start_next   = 1'b0;
        data_next    = uartData;
        if (request && state != IDLE) pending_next = 1'b1;
        case (state)
            IDLE: begin
                if (request || pending) begin
                    snap_load    = 1'b1;
                    pending_next = 1'b0;
                    index_next   = 3'd0;
                    state_next   = SEND;
                end
            end
            SEND: begin
                if (uartReady) begin
                    start_next = 1'b1;
                    data_next  = frame_byte;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!uartReady) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (uartReady) begin
                    if (index == LAST_INDEX) begin
                        index_next = 3'd0;
                        state_next = IDLE;
                    end else begin
                        index_next = index + 3'd1;
                        state_next = SEND;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            index        <= 3'd0;
            pending      <= 1'b0;
            uartStart    <= 1'b0;
            uartData     <= 8'h00;
            hours_snap   <= 6'd0;
            minutes_snap <= 6'd0;
        end else begin
            state     <= state_next;
            index     <= index_next;
            pending   <= pending_next;
            uartStart <= start_next;
            uartData  <= data_next;
            if (snap_load) begin
                hours_snap   <= hours;
                minutes_snap <= minutes;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_time_reporter.sv
// Bench for uart_time_reporter: two instances (CR LF and LF-only), each with a UART
// responder, a byte-level expectation queue and a per-cycle checker.
module tb_uart_time_reporter;

    typedef logic [7:0] bq_t [$];

    logic            clock = 1'b0;
    logic            reset;
    logic [5:0]      hours, minutes;
    logic [1:0]      req;
    logic [1:0]      force_low;
    logic [1:0]      rdy;
    logic [1:0]      st;
    logic [1:0]      bz;
    logic [1:0][7:0] dat;

    bq_t expq [2];
    bq_t cap  [2];
    bq_t f;
    int  vectors = 0;
    int  errors  = 0;
    int  n0;
    int  n;

    logic [7:0] exp030 [7] = '{8'h31, 8'h33, 8'h3A, 8'h30, 8'h37, 8'h0D, 8'h0A};

    always #5 clock = ~clock;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic bq_t frame(int h, int m, bit crlf);
        bq_t r;
        r.push_back(8'(48 + h / 10));
        r.push_back(8'(48 + h % 10));
        r.push_back(8'h3A);
        r.push_back(8'(48 + m / 10));
        r.push_back(8'(48 + m % 10));
        if (crlf) r.push_back(8'h0D);
        r.push_back(8'h0A);
        return r;
    endfunction

    task automatic push_frame(int g, int h, int m);
        bq_t r;
        r = frame(h, m, g == 1);
        foreach (r[i]) expq[g].push_back(r[i]);
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse(int g);
        req[g] = 1'b1;
        tick();
        req[g] = 1'b0;
    endtask

    task automatic wait_idle(int g, int budget);
        int k;
        k = 0;
        while ((expq[g].size() != 0 || bz[g] || !rdy[g]) && k < budget) begin
            tick();
            k++;
        end
        check($sformatf("lane%0d_idle_within_budget", g), k < budget, 1);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        logic       model_rdy = 1'b1;
        logic       prev_st   = 1'b0;
        logic [7:0] held      = 8'h00;
        int         cnt       = 0;

        assign rdy[g] = model_rdy & ~force_low[g];

        uart_time_reporter #(.Separator(8'h3A), .UseCrLf(g == 1)) dut (
            .clock       (clock),
            .reset       (reset),
            .sendRequest (req[g]),
            .minutes     (minutes),
            .hours       (hours),
            .uartReady   (rdy[g]),
            .uartStart   (st[g]),
            .uartData    (dat[g]),
            .busy        (bz[g])
        );

        always @(negedge clock) begin
            if (st[g]) begin
                check($sformatf("lane%0d_single_cycle_start", g), prev_st, 0);
                if (expq[g].size() == 0) check($sformatf("lane%0d_unexpected_start", g), 1, 0);
                else check($sformatf("lane%0d_byte", g), dat[g], expq[g].pop_front());
                cap[g].push_back(dat[g]);
                held = dat[g];
            end else if ((!model_rdy || force_low[g]) && bz[g] && !reset) begin
                check($sformatf("lane%0d_data_stable", g), dat[g], held);
            end
            prev_st = st[g];
            if (st[g]) begin
                model_rdy = 1'b0;
                cnt = 20;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) model_rdy = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 2'b00; force_low = 2'b00; hours = 6'd0; minutes = 6'd0;

        f = frame(13, 7, 1);
        check("model_len_crlf", f.size(), 7);
        for (int i = 0; i < 7; i++) check("model_bytes_13_07", f[i], exp030[i]);
        f = frame(0, 0, 0);
        check("model_len_lf", f.size(), 6);
        check("model_lf_last", f[5], 8'h0A);
        f = frame(63, 63, 1);
        check("model_63_tens", f[0], 8'h36);
        check("model_63_units", f[1], 8'h33);

        repeat (3) tick();
        req = 2'b11;
        tick();
        for (int g = 0; g < 2; g++) begin
            check("reset_start", st[g], 0);
            check("reset_busy", bz[g], 0);
            check("reset_data", dat[g], 8'h00);
        end
        reset = 1'b0;
        req = 2'b00;
        tick();
        check("req_at_reset_ignored_l1", bz[1], 0);
        check("req_at_reset_ignored_l0", bz[0], 0);

        // 13:07 with CR LF, including first-byte latency
        hours = 6'd13; minutes = 6'd7;
        push_frame(1, 13, 7);
        req[1] = 1'b1;
        tick();
        check("busy_after_request", bz[1], 1);
        check("no_start_at_k", st[1], 0);
        req[1] = 1'b0;
        tick();
        check("start_after_k_plus_1", st[1], 1);
        wait_idle(1, 2000);
        check("frame_13_07_len", cap[1].size(), 7);
        for (int i = 0; i < 7; i++) check("frame_13_07_byte", cap[1][i], exp030[i]);
        check("busy_low_after_frame", bz[1], 0);

        // LF-only instance, 00:00
        hours = 6'd0; minutes = 6'd0;
        push_frame(0, 0, 0);
        pulse(0);
        wait_idle(0, 2000);
        repeat (30) tick();
        check("lf_frame_len", cap[0].size(), 6);
        check("lf_frame_sep", cap[0][2], 8'h3A);
        check("lf_frame_last", cap[0][5], 8'h0A);

        // three requests during one frame -> one extra frame with fresh values
        n0 = cap[1].size();
        hours = 6'd5; minutes = 6'd10;
        push_frame(1, 5, 10);
        pulse(1);
        hours = 6'd6; minutes = 6'd11;
        push_frame(1, 6, 11);
        repeat (3) begin
            repeat (30) tick();
            pulse(1);
        end
        wait_idle(1, 2000);
        repeat (60) tick();
        check("pending_two_frames", cap[1].size() - n0, 14);

        // request held high across frames
        n0 = cap[1].size();
        hours = 6'd9; minutes = 6'd45;
        repeat (3) push_frame(1, 9, 45);
        req[1] = 1'b1;
        n = 0;
        while (cap[1].size() - n0 < 10 && n < 2000) begin
            tick();
            n++;
        end
        check("held_request_progress", n < 2000, 1);
        req[1] = 1'b0;
        wait_idle(1, 2000);
        repeat (60) tick();
        check("held_request_frames", cap[1].size() - n0, 21);

        // uartReady low at request
        force_low[1] = 1'b1;
        tick();
        hours = 6'd2; minutes = 6'd3;
        push_frame(1, 2, 3);
        pulse(1);
        repeat (10) begin
            tick();
            check("no_start_while_not_ready", st[1], 0);
        end
        check("busy_while_not_ready", bz[1], 1);
        force_low[1] = 1'b0;
        wait_idle(1, 2000);

        // reset after the third byte aborts the frame
        n0 = cap[1].size();
        hours = 6'd12; minutes = 6'd34;
        push_frame(1, 12, 34);
        pulse(1);
        n = 0;
        while (cap[1].size() - n0 < 3 && n < 2000) begin
            tick();
            n++;
        end
        check("abort_reached_third_byte", n < 2000, 1);
        reset = 1'b1;
        expq[1].delete();
        tick();
        check("abort_start", st[1], 0);
        check("abort_busy", bz[1], 0);
        check("abort_data", dat[1], 8'h00);
        reset = 1'b0;
        repeat (80) tick();
        check("abort_no_more_bytes", cap[1].size() - n0, 3);
        wait_idle(1, 2000);
        n0 = cap[1].size();
        push_frame(1, 12, 34);
        pulse(1);
        wait_idle(1, 2000);
        check("after_abort_full_frame", cap[1].size() - n0, 7);

        // out-of-range value 63 still converts digit by digit
        n0 = cap[1].size();
        hours = 6'd63; minutes = 6'd63;
        push_frame(1, 63, 63);
        pulse(1);
        wait_idle(1, 2000);
        check("v63_hours_tens", cap[1][n0], 8'h36);
        check("v63_minutes_units", cap[1][n0 + 4], 8'h33);

        // minute rollover: frame only when the auto-send feature is built in
        n0 = cap[1].size();
        hours = 6'd23; minutes = 6'd59;
`ifdef UART_TIME_REPORTER_AUTO_EN
        push_frame(1, 23, 59);
        push_frame(0, 23, 59);
`endif
        repeat (5) tick();
        hours = 6'd0; minutes = 6'd0;
`ifdef UART_TIME_REPORTER_AUTO_EN
        push_frame(1, 0, 0);
        push_frame(0, 0, 0);
        wait_idle(0, 4000);
        wait_idle(1, 4000);
        check("rollover_frames", cap[1].size() - n0, 14);
`else
        repeat (200) tick();
        check("rollover_no_frame", cap[1].size() - n0, 0);
`endif

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
